// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: instruction classes, major opcodes,
// the decoded-instruction record and the opcode classifier.
package riscv_pkg;

    // Instruction class presented on out_opclass
    typedef enum logic [3:0] {
        OPC_ALUREG  = 4'd0,
        OPC_ALUIMM  = 4'd1,
        OPC_BRANCH  = 4'd2,
        OPC_JAL     = 4'd3,
        OPC_JALR    = 4'd4,
        OPC_AUIPC   = 4'd5,
        OPC_LUI     = 4'd6,
        OPC_LOAD    = 4'd7,
        OPC_STORE   = 4'd8,
        OPC_SYSTEM  = 4'd9,
        OPC_FENCE   = 4'd10,
        OPC_ILLEGAL = 4'd11
    } opclass_t;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OP_ALUREG = 7'b0110011;
    localparam logic [6:0] OP_ALUIMM = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    // funct7 values that are legal for register-register ALU operations
    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    // Decoded fields of one instruction (the PC travels separately because
    // its width is a parameter of the stage)
    typedef struct packed {
        opclass_t    opclass;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        illegal;
    } decoded_t;

    // Map the opcode field onto an instruction class; anything that is not a
    // 32-bit encoding (low bits != 2'b11) or not a listed opcode is ILLEGAL.
    function automatic opclass_t classify(input logic [6:0] opcode);
        opclass_t cls;
        if (opcode[1:0] != 2'b11) begin
            cls = OPC_ILLEGAL;
        end else begin
            case (opcode)
                OP_ALUREG: cls = OPC_ALUREG;
                OP_ALUIMM: cls = OPC_ALUIMM;
                OP_BRANCH: cls = OPC_BRANCH;
                OP_JAL:    cls = OPC_JAL;
                OP_JALR:   cls = OPC_JALR;
                OP_AUIPC:  cls = OPC_AUIPC;
                OP_LUI:    cls = OPC_LUI;
                OP_LOAD:   cls = OPC_LOAD;
                OP_STORE:  cls = OPC_STORE;
                OP_SYSTEM: cls = OPC_SYSTEM;
                OP_FENCE:  cls = OPC_FENCE;
                default:   cls = OPC_ILLEGAL;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: selects the RV32I immediate format from the
// instruction class and sign-extends it to 32 bits. Purely combinational.
// Only instr[31:7] is needed; the opcode has already been folded into
// the class.
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:7] instr,
    input  opclass_t    opclass,
    output logic [31:0] imm
);

    logic [31:0] imm_i_s;
    logic [31:0] imm_s_s;
    logic [31:0] imm_b_s;
    logic [31:0] imm_j_s;
    logic [31:0] imm_u_s;

    // Assemble every format in parallel; the class picks one below
    always_comb begin
        imm_i_s = {{20{instr[31]}}, instr[31:20]};
        imm_s_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm_b_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                   instr[11:8], 1'b0};
        imm_j_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                   instr[30:21], 1'b0};
        imm_u_s = {instr[31:12], 12'h000};
    end

    // Format selection by instruction class
    always_comb begin
        imm = 32'h0000_0000;
        case (opclass)
            OPC_ALUIMM,
            OPC_JALR,
            OPC_LOAD,
            OPC_SYSTEM,
            OPC_FENCE:   imm = imm_i_s;
            OPC_STORE:   imm = imm_s_s;
            OPC_BRANCH:  imm = imm_b_s;
            OPC_JAL:     imm = imm_j_s;
            OPC_AUIPC,
            OPC_LUI:     imm = imm_u_s;
            OPC_ALUREG:  imm = 32'h0000_0000;
            default:     imm = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage. Decodes the incoming word combinationally and
// stores the result in a two-entry elastic buffer (main output register plus
// a skid register) so that in_ready can come straight from a flop while still
// sustaining one instruction per cycle.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int PC_WIDTH = 7
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [PC_WIDTH-1:0] in_pc,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [3:0]          out_opclass,
    output logic [4:0]          out_rd,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [2:0]          out_funct3,
    output logic [6:0]          out_funct7,
    output logic [31:0]         out_imm,
    output logic                out_illegal
);

    // ------------------------------------------------------------------
    // Decode of the word on the input side
    // ------------------------------------------------------------------
    opclass_t    cls_s;
    logic [31:0] imm_s;
    decoded_t    dec_s;
    logic        bad_funct7_s;

    // Classify the opcode field
    always_comb begin
        cls_s = classify(in_instr[6:0]);
    end

    imm_gen u_imm_gen (
        .instr   (in_instr[31:7]),
        .opclass (cls_s),
        .imm     (imm_s)
    );

    // Assemble the decoded record; register fields pass through untouched
    always_comb begin
        bad_funct7_s  = (in_instr[31:25] != F7_BASE) && (in_instr[31:25] != F7_ALT);
        dec_s         = '0;
        dec_s.opclass = cls_s;
        dec_s.rd      = in_instr[11:7];
        dec_s.rs1     = in_instr[19:15];
        dec_s.rs2     = in_instr[24:20];
        dec_s.funct3  = in_instr[14:12];
        dec_s.funct7  = in_instr[31:25];
        dec_s.imm     = imm_s;
        if (cls_s == OPC_ILLEGAL) begin
            dec_s.illegal = 1'b1;
        end else if (cls_s == OPC_ALUREG) begin
            dec_s.illegal = bad_funct7_s;
        end else begin
            dec_s.illegal = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Two-entry buffer state
    // ------------------------------------------------------------------
    logic                main_valid_r;
    logic [PC_WIDTH-1:0] main_pc_r;
    decoded_t            main_dec_r;
    logic                skid_valid_r;
    logic [PC_WIDTH-1:0] skid_pc_r;
    decoded_t            skid_dec_r;
    logic                in_ready_r;

    logic                main_valid_s;
    logic [PC_WIDTH-1:0] main_pc_s;
    decoded_t            main_dec_s;
    logic                skid_valid_s;
    logic [PC_WIDTH-1:0] skid_pc_s;
    decoded_t            skid_dec_s;
    logic                in_ready_s;

    logic                accept_s;
    logic                out_fire_s;
    logic                main_free_s;

    // Handshake qualifiers; a flush edge never takes a new word
    always_comb begin
        accept_s    = in_valid && in_ready_r && !flush;
        out_fire_s  = main_valid_r && out_ready;
        main_free_s = !main_valid_r || out_fire_s;
    end

    // Next-state of both entries. The main register refills from the skid
    // entry first so ordering is preserved; a new word lands in main when it
    // is free, otherwise in the skid register.
    always_comb begin
        main_valid_s = main_valid_r;
        main_pc_s    = main_pc_r;
        main_dec_s   = main_dec_r;
        skid_valid_s = skid_valid_r;
        skid_pc_s    = skid_pc_r;
        skid_dec_s   = skid_dec_r;
        if (flush) begin
            main_valid_s = 1'b0;
            skid_valid_s = 1'b0;
        end else if (main_free_s) begin
            if (skid_valid_r) begin
                main_valid_s = 1'b1;
                main_pc_s    = skid_pc_r;
                main_dec_s   = skid_dec_r;
                if (accept_s) begin
                    skid_valid_s = 1'b1;
                    skid_pc_s    = in_pc;
                    skid_dec_s   = dec_s;
                end else begin
                    skid_valid_s = 1'b0;
                end
            end else if (accept_s) begin
                main_valid_s = 1'b1;
                main_pc_s    = in_pc;
                main_dec_s   = dec_s;
            end else begin
                main_valid_s = 1'b0;
            end
        end else begin
            if (accept_s && !skid_valid_r) begin
                skid_valid_s = 1'b1;
                skid_pc_s    = in_pc;
                skid_dec_s   = dec_s;
            end else begin
                skid_valid_s = skid_valid_r;
            end
        end
    end

    // in_ready for the next cycle: open exactly when the skid slot is empty
    always_comb begin
        in_ready_s = !skid_valid_s;
    end

    // Buffer registers; reset clears validity and all output data fields
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            main_valid_r <= 1'b0;
            main_pc_r    <= '0;
            main_dec_r   <= '0;
            skid_valid_r <= 1'b0;
            skid_pc_r    <= '0;
            skid_dec_r   <= '0;
            in_ready_r   <= 1'b0;
        end else begin
            main_valid_r <= main_valid_s;
            main_pc_r    <= main_pc_s;
            main_dec_r   <= main_dec_s;
            skid_valid_r <= skid_valid_s;
            skid_pc_r    <= skid_pc_s;
            skid_dec_r   <= skid_dec_s;
            in_ready_r   <= in_ready_s;
        end
    end

    // ------------------------------------------------------------------
    // Outputs come straight from the main register and the ready flop
    // ------------------------------------------------------------------
    assign in_ready    = in_ready_r;
    assign out_valid   = main_valid_r;
    assign out_pc      = main_pc_r;
    assign out_opclass = main_dec_r.opclass;
    assign out_rd      = main_dec_r.rd;
    assign out_rs1     = main_dec_r.rs1;
    assign out_rs2     = main_dec_r.rs2;
    assign out_funct3  = main_dec_r.funct3;
    assign out_funct7  = main_dec_r.funct7;
    assign out_imm     = main_dec_r.imm;
    assign out_illegal = main_dec_r.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed decode vectors, backpressure,
// flush and mid-stream reset, plus a randomised stream checked by a scoreboard.
module tb_decode_stage;

    localparam int PCW = 7;

    logic            clock;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PCW-1:0]  in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [PCW-1:0]  out_pc;
    logic [3:0]      out_opclass;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [31:0]     out_imm;
    logic            out_illegal;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int pops_cnt   = 0;

    logic [127:0] sb_q[$];
    logic         prev_stall = 1'b0;
    logic [127:0] held_vec   = '0;

    decode_stage #(.PC_WIDTH(PCW)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_opclass (out_opclass),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_funct3  (out_funct3),
        .out_funct7  (out_funct7),
        .out_imm     (out_imm),
        .out_illegal (out_illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference decode, written from the RV32I encoding tables
    function automatic logic [127:0] ref_decode(input logic [31:0] w, input logic [PCW-1:0] pc);
        logic [3:0]         cls;
        logic signed [31:0] imm;
        logic signed [11:0] i12;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        logic               ill;
        logic [127:0]       r;
        case (w[6:0])
            7'h33:   cls = 4'd0;
            7'h13:   cls = 4'd1;
            7'h63:   cls = 4'd2;
            7'h6F:   cls = 4'd3;
            7'h67:   cls = 4'd4;
            7'h17:   cls = 4'd5;
            7'h37:   cls = 4'd6;
            7'h03:   cls = 4'd7;
            7'h23:   cls = 4'd8;
            7'h73:   cls = 4'd9;
            7'h0F:   cls = 4'd10;
            default: cls = 4'd11;
        endcase
        imm = 32'sd0;
        case (cls)
            4'd1, 4'd4, 4'd7, 4'd9, 4'd10: begin i12 = w[31:20]; imm = i12; end
            4'd8:       begin i12 = {w[31:25], w[11:7]}; imm = i12; end
            4'd2:       begin b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; imm = b13; end
            4'd3:       begin j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0}; imm = j21; end
            4'd5, 4'd6: imm = {w[31:12], 12'h000};
            default:    imm = 32'sd0;
        endcase
        ill = (cls == 4'd11) || ((cls == 4'd0) && (w[31:25] != 7'h00) && (w[31:25] != 7'h20));
        r = '0;
        r[68:0] = {pc, cls, w[11:7], w[19:15], w[24:20], w[14:12], w[31:25], imm, ill};
        return r;
    endfunction

    function automatic logic [127:0] obs_vec();
        logic [127:0] r;
        r = '0;
        r[68:0] = {out_pc, out_opclass, out_rd, out_rs1, out_rs2, out_funct3,
                   out_funct7, out_imm, out_illegal};
        return r;
    endfunction

    // Scoreboard: on the falling edge, pop/compare what leaves and push what enters
    always @(negedge clock) begin
        if (!reset) begin
            sb_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("hold_stable", {out_valid, obs_vec()}, {1'b1, held_vec});
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 128'(sb_q.size()), 128'd1);
                end else begin
                    chk("sb_out", obs_vec(), sb_q.pop_front());
                    pops_cnt++;
                end
            end
            if (flush)
                sb_q.delete();
            else if (in_valid && in_ready)
                sb_q.push_back(ref_decode(in_instr, in_pc));
            prev_stall = out_valid && !out_ready && !flush;
            held_vec   = obs_vec();
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Offer one word until accepted (bounded)
    task automatic send_word(input logic [31:0] w, input logic [PCW-1:0] pc);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_instr = w;
        in_pc    = pc;
        for (int k = 0; k < 20 && !acc; k++) begin
            acc = in_ready;
            step();
        end
        if (!acc) chk("send_timeout", 128'(acc), 128'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while ((sb_q.size() != 0 || out_valid) && n < 30) begin
            step();
            n++;
        end
        chk("drain_empty", 128'(sb_q.size()), 128'd0);
    endtask

    logic [31:0] burst[5];
    logic [6:0]  ops[13];

    initial begin
        int idx;
        int cyc;
        int pops_before;
        logic acc;
        logic [31:0] w;

        burst[0] = 32'h00A00113; burst[1] = 32'h002081B3; burst[2] = 32'h40208233;
        burst[3] = 32'h0000A283; burst[4] = 32'h00512023;
        ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h63; ops[3] = 7'h6F; ops[4] = 7'h67;
        ops[5] = 7'h17; ops[6] = 7'h37; ops[7] = 7'h03; ops[8] = 7'h23; ops[9] = 7'h73;
        ops[10] = 7'h0F; ops[11] = 7'h0B; ops[12] = 7'h30;

        reset = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b0;

        // Reset state
        step(); step();
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_out_data", obs_vec(), 128'd0);
        reset = 1'b1;
        chk("rel_no_edge_ready", 128'(in_ready), 128'd0);
        step();
        chk("rel_first_edge_ready", 128'(in_ready), 128'd1);
        chk("rel_out_valid", 128'(out_valid), 128'd0);

        // Directed decodes, one cycle latency into an empty stage
        out_ready = 1'b1;
        send_word(32'h00500093, 7'd3);
        chk("addi_valid", 128'(out_valid), 128'd1);
        chk("addi_class", 128'(out_opclass), 128'd1);
        chk("addi_rd", 128'(out_rd), 128'd1);
        chk("addi_rs1", 128'(out_rs1), 128'd0);
        chk("addi_funct3", 128'(out_funct3), 128'd0);
        chk("addi_imm", 128'(out_imm), 128'h00000005);
        chk("addi_pc", 128'(out_pc), 128'd3);
        send_word(32'hFE000EE3, 7'd4);
        chk("beq_class", 128'(out_opclass), 128'd2);
        chk("beq_rs1", 128'(out_rs1), 128'd0);
        chk("beq_rs2", 128'(out_rs2), 128'd0);
        chk("beq_imm", 128'(out_imm), 128'hFFFFFFFC);
        send_word(32'h123452B7, 7'd5);
        chk("lui_class", 128'(out_opclass), 128'd6);
        chk("lui_rd", 128'(out_rd), 128'd5);
        chk("lui_imm", 128'(out_imm), 128'h12345000);
        send_word(32'h00000000, 7'd6);
        chk("zero_class", 128'(out_opclass), 128'd11);
        chk("zero_illegal", 128'(out_illegal), 128'd1);
        send_word(32'h7E208233, 7'd7);
        chk("alureg_bad_f7_class", 128'(out_opclass), 128'd0);
        chk("alureg_bad_f7_illegal", 128'(out_illegal), 128'd1);
        drain();

        // Backpressure burst: out_ready low for the first 3 cycles
        pops_before = pops_cnt;
        idx = 0;
        cyc = 0;
        while (idx < 5 && cyc < 40) begin
            out_ready = (cyc >= 3);
            in_valid  = 1'b1;
            in_instr  = burst[idx];
            in_pc     = 7'(16 + idx);
            acc       = in_ready;
            step();
            cyc++;
            if (acc) begin
                idx++;
                if (idx == 2) chk("skid_full_ready", 128'(in_ready), 128'd0);
            end
        end
        chk("burst_accepts", 128'(idx), 128'd5);
        drain();
        chk("burst_no_loss", 128'(pops_cnt - pops_before), 128'd5);

        // Flush with both entries full and a word on offer
        out_ready = 1'b0;
        send_word(32'h00100093, 7'd30);
        send_word(32'h00200113, 7'd31);
        chk("flush_pre_ready", 128'(in_ready), 128'd0);
        in_valid = 1'b1; in_instr = 32'h00300193; in_pc = 7'd32;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 128'(out_valid), 128'd0);
        chk("flush_in_ready", 128'(in_ready), 128'd1);
        step();
        chk("flush_dropped", 128'(out_valid), 128'd0);

        // Reset pulsed mid-stream
        send_word(32'h00400213, 7'd40);
        send_word(32'h00500293, 7'd41);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_out_valid", 128'(out_valid), 128'd0);
        chk("async_rst_in_ready", 128'(in_ready), 128'd0);
        chk("async_rst_data", obs_vec(), 128'd0);
        step();
        reset = 1'b1;
        chk("mid_rel_no_edge_ready", 128'(in_ready), 128'd0);
        step();
        chk("mid_rel_edge_ready", 128'(in_ready), 128'd1);

        // Randomised stream through the scoreboard
        idx = 0;
        cyc = 0;
        w = {$urandom()};
        w[6:0] = ops[$urandom_range(0, 12)];
        while (idx < 60 && cyc < 2000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = w;
            in_pc     = 7'(idx);
            acc       = in_valid && in_ready;
            step();
            cyc++;
            if (acc) begin
                idx++;
                w = {$urandom()};
                w[6:0] = ops[$urandom_range(0, 12)];
                if (w[6:0] == 7'h33 && $urandom_range(0, 1) == 1)
                    w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            end
        end
        in_valid = 1'b0;
        chk("rand_accepts", 128'(idx), 128'd60);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 7, giving the width of the instruction address carried alongside each instruction word.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, upstream fetch presents an instruction.
REQ-005 SHALL have port in_ready, output, 1, stage accepts the input this cycle.
REQ-006 SHALL have port in_instr, input, 32, raw RV32I instruction word.
REQ-007 SHALL have port in_pc, input, PC_WIDTH, address of in_instr.
REQ-008 SHALL have port flush, input, 1, discards all held instructions.
REQ-009 SHALL have port out_valid, output, 1, decoded instruction available.
REQ-010 SHALL have port out_ready, input, 1, downstream consumes the output this cycle.
REQ-011 SHALL have ports out_pc (PC_WIDTH), out_opclass (4), out_rd (5), out_rs1 (5), out_rs2 (5), out_funct3 (3), out_funct7 (7), out_imm (32) and out_illegal (1), all outputs carrying the decoded fields of the head instruction.

Function
REQ-012 SHALL complete a transfer on any edge where valid and ready are both high, on each side independently.
REQ-013 SHALL register the decoded result, so an instruction accepted at edge N is presented with out_valid high after edge N when the stage was empty.
REQ-014 SHALL hold two entries: a main output register and a skid register.
REQ-015 SHALL drive in_ready directly from a flop, high exactly when the skid register is empty.
REQ-016 SHALL present instructions in acceptance order and SHALL never drop or duplicate one except on flush or reset.
REQ-017 SHALL hold every out_* signal stable while out_valid is high and out_ready is low.
REQ-018 SHALL move the skid entry into the main register on the edge the main entry is consumed, and SHALL allow a simultaneous input accept on that edge.
REQ-019 SHALL decode out_opclass from instr[6:0] into ALUREG, ALUIMM, BRANCH, JAL, JALR, AUIPC, LUI, LOAD, STORE, SYSTEM, FENCE or ILLEGAL.
REQ-020 SHALL sign-extend the immediate from instr[31] to 32 bits using the I-, S-, B- or J-format for the class, with bit 0 forced to zero for B and J; U-format SHALL be instr[31:12] followed by 12 zeros; ALUREG SHALL give 0.
REQ-021 SHALL pass rd, rs1, rs2, funct3 and funct7 unconditionally from their fixed bit positions.
REQ-022 SHALL set out_illegal, with out_opclass ILLEGAL, when instr[1:0] is not 2'b11 or the opcode is unlisted.
REQ-023 SHALL also set out_illegal when the class is ALUREG and funct7 is neither 0x00 nor 0x20.
REQ-024 SHALL, on flush, clear both entries at the next edge and ignore any in_valid on that edge; in_ready SHALL be high on the following cycle.

Reset
REQ-025 SHALL, while reset is low, force out_valid to 0, in_ready to 0, both entry valid flags to 0, and all out_* data fields to 0.
REQ-026 SHALL raise in_ready on the first clock edge after reset deasserts.
REQ-027 SHALL, on reset asserted mid-operation, discard held entries immediately and asynchronously.

Structure
REQ-028 SHALL take the opclass enum, the 7-bit opcode constants and a packed decoded-instruction struct from shared package riscv_pkg.
REQ-029 SHALL place immediate generation in one combinational sub-module, imm_gen, that takes the instruction and opclass and returns out_imm.

Verification
REQ-030 SHALL check that in_instr 0x00500093 at in_pc 3 gives ALUIMM, rd=1, rs1=0, funct3=0, imm=0x00000005, out_pc 3, one cycle later.
REQ-031 SHALL check that 0xFE000EE3 gives BRANCH, rs1=0, rs2=0, imm=0xFFFFFFFC.
REQ-032 SHALL check that 0x123452B7 gives LUI, rd=5, imm=0x12345000, and that 0x00000000 gives ILLEGAL with out_illegal=1.
REQ-033 SHALL check that with in_valid held high on 5 sequential words and out_ready low for 3 cycles, in_ready falls after the 2nd accept and all 5 words emerge in order with no loss.
REQ-034 SHALL check that flush asserted with both entries full and in_valid high leaves out_valid=0 next cycle, drops the offered word, and raises in_ready.
REQ-035 SHALL check that reset pulsed low mid-stream forces out_valid=0 and in_ready=0 asynchronously, and that in_ready=1 one edge after release.
